exec_addx_mw: RTL
=================

# exec_addx_mw

Multi-word add/subtract sequencer for the `exec_addx` adder datapath. It accepts one command (add or sub, word count, optional carry-in) and then a stream of operand word pairs, least-significant word first. For each pair it drives the adder with the correct select and chained carry/borrow, returns one result word per pair, and reports the aggregate flags of the full-width result. It sits in the execute stage between issue and the adder, so the ISA can provide wide arithmetic without a wider adder.

## Interface
- `W_OPR`, from `params.v`: datapath word width.
- `W_FLAGS`, from `params.v` (4): flags layout `{overflow, sign, zero, carry}`.
- `MAX_WORDS`, 8: maximum words per command.
- `W_CNT`, `$clog2(MAX_WORDS)`: width of the word-count field.

Ports:
- `clk_i` input 1: single clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `cmd_valid_i` input 1: command request.
- `cmd_ready_o` output 1: high only in IDLE.
- `cmd_sub_i` input 1: 1 = subtract (opr0 − opr1), 0 = add.
- `cmd_cin_i` input 1: 1 = first word uses incoming carry (adc/sbb).
- `cmd_flags_i` input `W_FLAGS`: incoming flags; only bit 0 is used.
- `cmd_words_i` input `W_CNT`: word count minus 1 (0 means 1 word).
- `opr_valid_i`, `opr_ready_o` 1 each: operand handshake.
- `opr0_i`, `opr1_i` input `W_OPR`: operand word pair.
- `res_valid_o` output 1, `res_ready_i` input 1: result handshake.
- `res_o` output `W_OPR`: result word.
- `res_last_o` output 1: marks the final word of the command.
- `done_o` output 1: one-cycle pulse when aggregate flags are valid.
- `flags_o` output `W_FLAGS`: aggregate flags, held until the next `done_o`.
- `busy_o` output 1: high when state is not IDLE.

## Operation
- **States:** IDLE and RUN.
- **IDLE → RUN:** on `cmd_valid_i & cmd_ready_o`. The block latches `sub`, `cin` and `remaining = cmd_words_i`, and sets `chain = cmd_flags_i[0]`, `first = 1`, `zacc = 1`.
- **Operand acceptance:** `opr_ready_o = (state==RUN) & (~res_valid_o | res_ready_i)`. An operand is accepted on `opr_valid_i & opr_ready_o`.
- **Adder drive for each accepted pair:**
  - `select = {first ? cin : 1, sub}`.
  - Adder `flags_i[0] = chain`.
  - The adder output is written to the `res_o` register and `res_valid_o` is set.
- **Carry chaining after each word (c = raw adder carry-out):**
  - Add: `chain = c`.
  - Sub: `chain = ~c`. This stores a borrow, because the adder computes `cin = 1 ^ C` for select 11.
  - `first` is cleared and `zacc &= word_zero`.
- **Last word (`remaining == 0`):**
  - `res_last_o` is set with that result.
  - `flags_o = {V_last, S_last, zacc & Z_last, c_last}`, where carry is the raw adder carry.
  - `done_o` pulses and the state returns to IDLE.
- **Otherwise:** `remaining` decrements.
- **Result handshake:** `res_valid_o` clears on `res_ready_i` unless a new word is loaded in the same cycle.
- **Command while the last result is pending:** a new command can be accepted in IDLE while the last result is still waiting. Its operands stall until the result register frees.
- **Reset, including mid-command:**
  - State goes to IDLE. `res_valid_o`, `res_last_o`, `done_o`, `busy_o`, `res_o` and `flags_o` go to 0. `cmd_ready_o` goes to 1 and `opr_ready_o` to 0.
  - Any partial command is discarded and its operands are not replayed.

## Timing
- **Latency:** `res_o` is valid the cycle after operand acceptance.
- **Throughput:** 1 word/cycle with `res_ready_i` held high.
- **Flags:** `done_o` and `flags_o` update on the same edge that presents the last result (`res_last_o=1`).
- **Back-to-back commands:** the minimum command-to-command gap is 1 IDLE cycle.
- **Backpressure:** `res_ready_i` low stalls `opr_ready_o` combinationally in the same cycle. No word is dropped or duplicated.
- **Stable outputs:** `res_o` and `res_last_o` are stable while `res_valid_o & ~res_ready_i`.

## Structure
- Flag bit indices (`F_C=0`, `F_Z=1`, `F_S=2`, `F_V=3`) and the state encoding belong in the shared `params.v`.
- Instantiate `exec_addx` as the single sub-module. The controller holds no arithmetic beyond the zero accumulator and the counter.

## Test plan
Use `W_OPR=16` on the bench.
1. **2-word add:** 0x0001_FFFF + 0x0000_0001 → words 0x0000 then 0x0002, `res_last_o` on the 2nd word, flags V=0 S=0 Z=0 C=0.
2. **2-word sub with borrow:** 0x0001_0000 − 0x0000_0001 → 0xFFFF then 0x0000, flags Z=0 S=0 C=1.
3. **3-word self-subtract:** 0x1234_5678_9ABC − same → three 0x0000 words, Z=1, C=1, V=0.
4. **1-word with carry-in:** 0x7FFF + 0x0000 with `cmd_cin_i=1` and `cmd_flags_i[0]=1` → 0x8000, V=1, S=1. Separately, 0x7FFF + 0x0001 add → 0x8000, V=1.
5. **Backpressure:** 4-word add with `res_ready_i` low for 3 cycles after word 2 → `opr_ready_o` low for exactly those cycles, all 4 results in order, single `done_o`.
6. **Reset mid-command:** assert `rst_i` after word 1 of 3 → all outputs return to reset values asynchronously. A following 1-word command 0x0003+0x0004 gives 0x0007 and correct flags.

Source files
------------

// File: rtl/exec_addx_mw_pkg.sv
// Shared constants, flag layout and sequencer state encoding for the
// multi-word add/subtract sequencer and its adder.
package exec_addx_mw_pkg;

    localparam int W_OPR     = 16;
    localparam int W_FLAGS   = 4;
    localparam int MAX_WORDS = 8;
    localparam int W_CNT     = $clog2(MAX_WORDS);

    localparam int F_C = 0;
    localparam int F_Z = 1;
    localparam int F_S = 2;
    localparam int F_V = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Adder select: bit 1 = use incoming carry, bit 0 = subtract.
    // Every word after the first always chains the previous carry/borrow.
    function automatic logic [1:0] word_select(input logic first, input logic cin,
                                               input logic sub);
        return {(first ? cin : 1'b1), sub};
    endfunction

endpackage

// File: rtl/exec_addx.sv
// Single-word adder: add/sub with optional carry (adc) or borrow (sbb) input,
// producing the result word and {V, S, Z, C} flags with C the raw carry-out.
module exec_addx
    import exec_addx_mw_pkg::*;
(
    input  logic [W_OPR-1:0]   i_opr0,
    input  logic [W_OPR-1:0]   i_opr1,
    input  logic [1:0]         i_select,
    input  logic [W_FLAGS-1:0] i_flags,
    output logic [W_OPR-1:0]   o_res,
    output logic [W_FLAGS-1:0] o_flags
);

    logic [W_OPR-1:0] w_b;
    logic             w_cin;
    logic [W_OPR:0]   w_sum;
    logic [W_OPR-1:0] w_res;

    always_comb begin
        w_b = i_select[0] ? ~i_opr1 : i_opr1;
        // Subtract-with-borrow inverts the stored borrow into the carry-in.
        case (i_select)
            2'b00:   w_cin = 1'b0;
            2'b01:   w_cin = 1'b1;
            2'b10:   w_cin = i_flags[F_C];
            default: w_cin = ~i_flags[F_C];
        endcase
        w_sum = {1'b0, i_opr0} + {1'b0, w_b} + {{W_OPR{1'b0}}, w_cin};
        w_res = w_sum[W_OPR-1:0];

        o_res        = w_res;
        o_flags      = '0;
        o_flags[F_C] = w_sum[W_OPR];
        o_flags[F_Z] = (w_res == '0);
        o_flags[F_S] = w_res[W_OPR-1];
        o_flags[F_V] = (i_opr0[W_OPR-1] == w_b[W_OPR-1]) &&
                       (w_res[W_OPR-1] != i_opr0[W_OPR-1]);
    end

endmodule

// File: rtl/exec_addx_mw.sv
// Multi-word add/subtract sequencer: takes one command, then streams operand
// word pairs LSW first through exec_addx, chaining carry/borrow between words.
module exec_addx_mw
    import exec_addx_mw_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_sub_i,
    input  logic               cmd_cin_i,
    input  logic [W_FLAGS-1:0] cmd_flags_i,
    input  logic [W_CNT-1:0]   cmd_words_i,
    input  logic               opr_valid_i,
    output logic               opr_ready_o,
    input  logic [W_OPR-1:0]   opr0_i,
    input  logic [W_OPR-1:0]   opr1_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [W_OPR-1:0]   res_o,
    output logic               res_last_o,
    output logic               done_o,
    output logic [W_FLAGS-1:0] flags_o,
    output logic               busy_o
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sub;
    logic               r_cin;
    logic               r_chain;
    logic               r_first;
    logic               r_zacc;
    logic [W_CNT-1:0]   r_remaining;
    logic [W_OPR-1:0]   r_res;
    logic               r_res_valid;
    logic               r_res_last;
    logic               r_done;
    logic [W_FLAGS-1:0] r_flags;

    logic               w_cmd_acc;
    logic               w_opr_acc;
    logic               w_last;
    logic [1:0]         w_sel;
    logic [W_FLAGS-1:0] w_add_flags_in;
    logic [W_OPR-1:0]   w_add_res;
    logic [W_FLAGS-1:0] w_add_flags;
    logic [W_FLAGS-1:0] w_flags_agg;

    assign cmd_ready_o    = (r_state == ST_IDLE);
    assign busy_o         = (r_state != ST_IDLE);
    assign opr_ready_o    = (r_state == ST_RUN) & (~r_res_valid | res_ready_i);
    assign w_cmd_acc      = cmd_valid_i & cmd_ready_o;
    assign w_opr_acc      = opr_valid_i & opr_ready_o;
    assign w_last         = w_opr_acc & (r_remaining == '0);
    assign w_sel          = word_select(r_first, r_cin, r_sub);
    assign w_add_flags_in = {{(W_FLAGS-1){1'b0}}, r_chain};

    assign res_valid_o = r_res_valid;
    assign res_o       = r_res;
    assign res_last_o  = r_res_last;
    assign done_o      = r_done;
    assign flags_o     = r_flags;

    exec_addx u_addx (
        .i_opr0   (opr0_i),
        .i_opr1   (opr1_i),
        .i_select (w_sel),
        .i_flags  (w_add_flags_in),
        .o_res    (w_add_res),
        .o_flags  (w_add_flags)
    );

    // Zero flag covers the whole multi-word result, not just the last word.
    always_comb begin
        w_flags_agg      = w_add_flags;
        w_flags_agg[F_Z] = r_zacc & w_add_flags[F_Z];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_cmd_acc) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sub       <= 1'b0;
            r_cin       <= 1'b0;
            r_chain     <= 1'b0;
            r_first     <= 1'b1;
            r_zacc      <= 1'b1;
            r_remaining <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_done      <= 1'b0;
            r_flags     <= '0;
        end else begin
            r_done <= w_last;
            if (w_cmd_acc) begin
                r_sub       <= cmd_sub_i;
                r_cin       <= cmd_cin_i;
                r_remaining <= cmd_words_i;
                r_chain     <= cmd_flags_i[F_C];
                r_first     <= 1'b1;
                r_zacc      <= 1'b1;
            end
            // Subtract keeps a borrow in r_chain: raw carry-out inverted.
            if (w_opr_acc) begin
                r_res       <= w_add_res;
                r_res_valid <= 1'b1;
                r_res_last  <= w_last;
                r_chain     <= r_sub ? ~w_add_flags[F_C] : w_add_flags[F_C];
                r_first     <= 1'b0;
                r_zacc      <= r_zacc & w_add_flags[F_Z];
                if (w_last) r_flags     <= w_flags_agg;
                else        r_remaining <= r_remaining - 1'b1;
            end else if (res_ready_i) begin
                r_res_valid <= 1'b0;
            end
        end
    end

endmodule
